pixel_column_adc: RTL

- Parametrised successor to the single-pixel sensor: one controller sequences erase, expose, ramp-convert and readout for N_PIX pixels that share a single digital ramp counter.
- Each pixel supplies a comparator bit. The block latches the ramp code at which each comparator first trips.
- It then streams the per-pixel codes out over a valid/ready bus.
- It sits between the analog pixel column models and the frame capture logic.

---
 rtl/pixel_column_adc_pkg.sv | 37 +++
 rtl/pixel_column_adc_if.sv | 19 +
 rtl/pixel_column_adc_latch_bank.sv | 62 ++++++
 rtl/pixel_column_adc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_column_adc_pkg.sv
// Shared types and Gray/binary helpers for the pixel column ADC.
// Helpers work on a MAX_W-bit container; the width argument masks the result.
package pixel_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READOUT
  } state_t;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    logic [MAX_W-1:0] m;
    if (w >= MAX_W) m = '1;
    else            m = (MAX_W'(1) << w) - MAX_W'(1);
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(w);
    b[MAX_W-1] = gm[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_column_adc_if.sv
// Readout bus from the column ADC to the frame capture logic.
// Handshake: a word moves on a clock edge where dout_valid && dout_ready; while
// dout_valid is high and dout_ready low, dout/dout_idx/dout_sat hold, and
// dout_valid never drops without a transfer. All data fields are 0 when invalid.
interface pixel_column_adc_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
);
  logic [WIDTH-1:0] dout;
  logic [IDX_W-1:0] dout_idx;
  logic             dout_sat;
  logic             dout_valid;
  logic             dout_ready;

  modport master (output dout, output dout_idx, output dout_sat, output dout_valid,
                  input dout_ready);
  modport slave  (input dout, input dout_idx, input dout_sat, input dout_valid,
                  output dout_ready);
endinterface

// File: rtl/pixel_column_adc_latch_bank.sv
// Per-pixel code registers with latched/saturated flags sharing one ramp code.
// Next-state values are exported so readout can load the final codes on the last ramp edge.
module pixel_latch_bank #(
  parameter int               WIDTH    = 8,
  parameter int               N_PIX    = 4,
  parameter logic [WIDTH-1:0] SAT_CODE = '1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         sample_i,
  input  logic                         finalize_i,
  input  logic [WIDTH-1:0]             code_i,
  input  logic [N_PIX-1:0]             cmp_i,
  output logic [N_PIX-1:0][WIDTH-1:0]  code_nxt_o,
  output logic [N_PIX-1:0]             sat_nxt_o
);

  logic [N_PIX-1:0][WIDTH-1:0] code_q, code_d;
  logic [N_PIX-1:0]            lat_q, lat_d;
  logic [N_PIX-1:0]            sat_q, sat_d;

  always_comb begin
    code_d = code_q;
    lat_d  = lat_q;
    sat_d  = sat_q;
    if (clear_i) begin
      code_d = '0;
      lat_d  = '0;
      sat_d  = '0;
    end else begin
      for (int i = 0; i < N_PIX; i++) begin
        if (sample_i && !lat_q[i] && cmp_i[i]) begin
          code_d[i] = code_i;
          lat_d[i]  = 1'b1;
        end
        // A pixel still unlatched after the final ramp step saturates.
        if (finalize_i && !lat_d[i]) begin
          code_d[i] = SAT_CODE;
          sat_d[i]  = 1'b1;
          lat_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q <= '0;
      lat_q  <= '0;
      sat_q  <= '0;
    end else begin
      code_q <= code_d;
      lat_q  <= lat_d;
      sat_q  <= sat_d;
    end
  end

  assign code_nxt_o = code_d;
  assign sat_nxt_o  = sat_d;

endmodule

// File: rtl/pixel_column_adc.sv
// Column ADC controller: erase, expose, shared-ramp conversion and readout of N_PIX pixels.
// Define PIXEL_GRAY_CODE_EN to drive a Gray-coded ramp; DOUT stays binary either way.
module pixel_column_adc
  import pixel_adc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_PIX     = 4,
  parameter int ERASE_CYC = 5,
  parameter int TEXP_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [TEXP_W-1:0]    expose_time_i,
  input  logic [N_PIX-1:0]     cmp_i,
  output logic                 erase_o,
  output logic                 expose_o,
  output logic                 ramp_en_o,
  output logic [WIDTH-1:0]     ramp_code_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output state_t               state_o,
  pixel_column_adc_if.master   dout_bus
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [WIDTH-1:0] CODE_MAX = '1;
`ifdef PIXEL_GRAY_CODE_EN
  localparam logic [WIDTH-1:0] SAT_CODE = WIDTH'(1) << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] SAT_CODE = '1;
`endif

  function automatic logic [WIDTH-1:0] enc_code(input logic [WIDTH-1:0] b);
`ifdef PIXEL_GRAY_CODE_EN
    return WIDTH'(bin2gray(MAX_W'(b), WIDTH));
`else
    return b;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] dec_code(input logic [WIDTH-1:0] g);
`ifdef PIXEL_GRAY_CODE_EN
    return WIDTH'(gray2bin(MAX_W'(g), WIDTH));
`else
    return g;
`endif
  endfunction

  state_t                      state_q;
  logic                        pend_q;
  logic [TEXP_W-1:0]           texp_q, timer_q;
  logic [WIDTH-1:0]            cnt_q, cnt_inc, ramp_code_q, dout_q;
  logic [IDX_W-1:0]            idx_q, idx_inc;
  logic                        erase_q, expose_q, ramp_en_q, busy_q, frame_done_q;
  logic                        valid_q, sat_q;
  logic                        bank_clear, bank_sample, bank_final;
  logic [N_PIX-1:0][WIDTH-1:0] code_nxt;
  logic [N_PIX-1:0]            sat_nxt;

  assign cnt_inc     = cnt_q + WIDTH'(1);
  assign idx_inc     = idx_q + IDX_W'(1);
  assign bank_clear  = (state_q == ERASE);
  assign bank_sample = (state_q == CONVERT);
  assign bank_final  = (state_q == CONVERT) && (cnt_q == CODE_MAX);

  pixel_latch_bank #(
    .WIDTH    (WIDTH),
    .N_PIX    (N_PIX),
    .SAT_CODE (SAT_CODE)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (bank_clear),
    .sample_i   (bank_sample),
    .finalize_i (bank_final),
    .code_i     (ramp_code_q),
    .cmp_i      (cmp_i),
    .code_nxt_o (code_nxt),
    .sat_nxt_o  (sat_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      texp_q       <= '0;
      timer_q      <= '0;
      cnt_q        <= '0;
      ramp_code_q  <= '0;
      idx_q        <= '0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      valid_q      <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      ramp_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Accepted START spends one cycle here so ERASE begins on the following edge.
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            timer_q <= TEXP_W'(ERASE_CYC - 1);
          end else if (start_i) begin
            pend_q <= 1'b1;
            texp_q <= (expose_time_i == '0) ? TEXP_W'(1) : expose_time_i;
          end
        end
        ERASE: begin
          if (timer_q == '0) begin
            state_q  <= EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            timer_q  <= texp_q - TEXP_W'(1);
          end else begin
            timer_q <= timer_q - TEXP_W'(1);
          end
        end
        EXPOSE: begin
          if (timer_q == '0) begin
            state_q     <= CONVERT;
            expose_q    <= 1'b0;
            ramp_en_q   <= 1'b1;
            cnt_q       <= '0;
            ramp_code_q <= '0;
          end else begin
            timer_q <= timer_q - TEXP_W'(1);
          end
        end
        CONVERT: begin
          if (cnt_q == CODE_MAX) begin
            state_q     <= READOUT;
            ramp_en_q   <= 1'b0;
            ramp_code_q <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b1;
            dout_q      <= dec_code(code_nxt[0]);
            sat_q       <= sat_nxt[0];
          end else begin
            cnt_q       <= cnt_inc;
            ramp_code_q <= enc_code(cnt_inc);
          end
        end
        READOUT: begin
          if (dout_bus.dout_ready) begin
            if (idx_q == IDX_W'(N_PIX - 1)) begin
              state_q      <= IDLE;
              valid_q      <= 1'b0;
              dout_q       <= '0;
              idx_q        <= '0;
              sat_q        <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q  <= idx_inc;
              dout_q <= dec_code(code_nxt[idx_inc]);
              sat_q  <= sat_nxt[idx_inc];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign erase_o             = erase_q;
  assign expose_o            = expose_q;
  assign ramp_en_o           = ramp_en_q;
  assign ramp_code_o         = ramp_code_q;
  assign busy_o              = busy_q;
  assign frame_done_o        = frame_done_q;
  assign state_o             = state_q;
  assign dout_bus.dout       = dout_q;
  assign dout_bus.dout_idx   = idx_q;
  assign dout_bus.dout_sat   = sat_q;
  assign dout_bus.dout_valid = valid_q;

endmodule
